// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity-type codes and baud helper.
package uart_pkg;

  // FSM state encoding for the transmit (and future receive) framers
  typedef logic [2:0] uartState_t;

  localparam uartState_t IDLE   = 3'd0;
  localparam uartState_t START  = 3'd1;
  localparam uartState_t DATA   = 3'd2;
  localparam uartState_t PARITY = 3'd3;
  localparam uartState_t STOP   = 3'd4;

  // Parity-type selection shared with the upstream parity generator
  localparam logic [1:0] EVEN  = 2'd0;
  localparam logic [1:0] ODD   = 2'd1;
  localparam logic [1:0] MARK0 = 2'd2;
  localparam logic [1:0] MARK1 = 2'd3;

  // Clocks per line bit; truncating division, so the bit rate rounds up slightly
  function automatic int calcClksPerBit(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tc_o
// on the last count. Held at zero while disabled so every bit starts aligned.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == TC_VAL);

  // Next count: clear when idle or at terminal count, otherwise increment
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: accepts a word plus precomputed parity via valid/ready
// and serializes start, data (LSB first), optional parity and stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  parity_in,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = calcClksPerBit(CLK_FREQ, BAUD_RATE);
  localparam int BIT_CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : gBadBaud
    $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : gBadWidth
    $error("uart_tx_frame: DATA_WIDTH must be within 5..9");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : gBadParity
    $error("uart_tx_frame: PARITY_EN must be 0 or 1");
  end

  uartState_t            state_q,  state_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic                  parity_q, parity_d;
  logic [BIT_CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic                  txOut_q,  txOut_d;
  logic                  ready_q,  ready_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  baudTc;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) uBaudCnt (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .en_i   (state_q != IDLE),
    .tc_o   (baudTc)
  );

  // Frame sequencing: every output is computed here and registered below
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bitCnt_d = bitCnt_q;
    txOut_d  = txOut_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d  = tx_data;
          parity_d = parity_in;
          bitCnt_d = '0;
          txOut_d  = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (baudTc) begin
          state_d  = DATA;
          txOut_d  = shift_q[0];
          shift_d  = shift_q >> 1;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (baudTc) begin
          if (bitCnt_q == LAST_DATA) begin
            bitCnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txOut_d = parity_q;
            end else begin
              state_d = STOP;
              txOut_d = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
            txOut_d  = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (baudTc) begin
          state_d  = STOP;
          txOut_d  = 1'b1;
          bitCnt_d = '0;
        end
      end
      STOP: begin
        if (baudTc) begin
          if (bitCnt_q == LAST_STOP) begin
            state_d  = IDLE;
            txOut_d  = 1'b1;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            done_d   = 1'b1;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        txOut_d  = 1'b1;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
        bitCnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset truncates any frame and idles the line
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      bitCnt_q <= '0;
      txOut_q  <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      bitCnt_q <= bitCnt_d;
      txOut_q  <= txOut_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_out   = txOut_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: two instances at 10 clocks/bit, one with parity
// and one stop bit (A), one without parity and two stop bits (B).
module tb_uart_tx_frame;

  localparam int CPB = 10;

  logic       sysClk;
  logic       sysRstN;
  logic [7:0] txDataA, txDataB;
  logic       parityA, parityB;
  logic       validA, validB;
  logic       readyA, readyB;
  logic       outA, outB;
  logic       busyA, busyB;
  logic       doneA, doneB;

  int compareCount;
  int mismatchCount;

  logic expQA[$];
  logic expQB[$];

  uart_tx_frame #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_WIDTH (8),
    .PARITY_EN  (1),
    .STOP_BITS  (1)
  ) dutA (
    .sys_clk   (sysClk),
    .sys_rst_n (sysRstN),
    .tx_data   (txDataA),
    .parity_in (parityA),
    .tx_valid  (validA),
    .tx_ready  (readyA),
    .tx_out    (outA),
    .tx_busy   (busyA),
    .tx_done   (doneA)
  );

  uart_tx_frame #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_WIDTH (8),
    .PARITY_EN  (0),
    .STOP_BITS  (2)
  ) dutB (
    .sys_clk   (sysClk),
    .sys_rst_n (sysRstN),
    .tx_data   (txDataB),
    .parity_in (parityB),
    .tx_valid  (validB),
    .tx_ready  (readyB),
    .tx_out    (outB),
    .tx_busy   (busyB),
    .tx_done   (doneB)
  );

  // 10-unit clock period
  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Bits per frame for each instance
  function automatic int frameBits(input int sel);
    return (sel == 0) ? (1 + 8 + 1 + 1) : (1 + 8 + 0 + 2);
  endfunction

  // Line/handshake outputs must all show the idle state
  task automatic checkIdle(input int sel, input string tag);
    if (sel == 0) begin
      checkOutput({tag, " A tx_out"},   32'(outA),   32'd1);
      checkOutput({tag, " A tx_ready"}, 32'(readyA), 32'd1);
      checkOutput({tag, " A tx_busy"},  32'(busyA),  32'd0);
      checkOutput({tag, " A tx_done"},  32'(doneA),  32'd0);
    end else begin
      checkOutput({tag, " B tx_out"},   32'(outB),   32'd1);
      checkOutput({tag, " B tx_ready"}, 32'(readyB), 32'd1);
      checkOutput({tag, " B tx_busy"},  32'(busyB),  32'd0);
      checkOutput({tag, " B tx_done"},  32'(doneB),  32'd0);
    end
  endtask

  // Drive a word at a negedge, push its expected frame at the accept edge,
  // and return at the following negedge (first cycle of the start bit)
  task automatic applyStimulus(input int sel, input logic [7:0] data,
                               input logic par, input logic holdValid);
    if (sel == 0) begin
      txDataA = data; parityA = par; validA = 1'b1;
    end else begin
      txDataB = data; parityB = par; validB = 1'b1;
    end
    @(posedge sysClk);
    if (sel == 0) begin
      expQA.push_back(1'b0);
      for (int i = 0; i < 8; i++) expQA.push_back(data[i]);
      expQA.push_back(par);
      expQA.push_back(1'b1);
    end else begin
      expQB.push_back(1'b0);
      for (int i = 0; i < 8; i++) expQB.push_back(data[i]);
      expQB.push_back(1'b1);
      expQB.push_back(1'b1);
    end
    @(negedge sysClk);
    if (!holdValid) begin
      if (sel == 0) validA = 1'b0;
      else          validB = 1'b0;
    end
  endtask

  // Pop one frame from the scoreboard and compare the line cycle by cycle.
  // stopAfter >= 0 ends early at that cycle (remaining bits are discarded);
  // otherwise the completion cycle is checked too. scramble disturbs the
  // inputs every cycle, which the framer must ignore.
  task automatic checkFrame(input int sel, input logic scramble, input int stopAfter);
    logic bits[$];
    int   nBits;
    int   len;
    logic obsOut, obsDone;
    nBits = frameBits(sel);
    for (int i = 0; i < nBits; i++) begin
      if (sel == 0) bits.push_back(expQA.pop_front());
      else          bits.push_back(expQB.pop_front());
    end
    len = nBits * CPB;
    if (sel == 0) begin
      checkOutput("start A tx_busy",  32'(busyA),  32'd1);
      checkOutput("start A tx_ready", 32'(readyA), 32'd0);
    end else begin
      checkOutput("start B tx_busy",  32'(busyB),  32'd1);
      checkOutput("start B tx_ready", 32'(readyB), 32'd0);
    end
    for (int k = 0; k < len; k++) begin
      if (k == stopAfter) return;
      obsOut  = (sel == 0) ? outA  : outB;
      obsDone = (sel == 0) ? doneA : doneB;
      checkOutput($sformatf("dut%0d cycle %0d line", sel, k), 32'(obsOut), 32'(bits[k / CPB]));
      checkOutput($sformatf("dut%0d cycle %0d tx_done", sel, k), 32'(obsDone), 32'd0);
      if (scramble && sel == 0) begin
        txDataA = 8'($urandom);
        parityA = 1'($urandom);
        validA  = (k < len - CPB) ? 1'($urandom) : 1'b0;
      end
      @(negedge sysClk);
    end
    if (sel == 0) begin
      checkOutput("end A tx_done",  32'(doneA),  32'd1);
      checkOutput("end A tx_ready", 32'(readyA), 32'd1);
      checkOutput("end A tx_busy",  32'(busyA),  32'd0);
      checkOutput("end A tx_out",   32'(outA),   32'd1);
    end else begin
      checkOutput("end B tx_done",  32'(doneB),  32'd1);
      checkOutput("end B tx_ready", 32'(readyB), 32'd1);
      checkOutput("end B tx_busy",  32'(busyB),  32'd0);
      checkOutput("end B tx_out",   32'(outB),   32'd1);
    end
  endtask

  // Main sequence
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    sysRstN = 1'b0;
    txDataA = 8'h00; parityA = 1'b0; validA = 1'b1;
    txDataB = 8'h00; parityB = 1'b0; validB = 1'b1;

    $display("[TB] reset held with tx_valid high");
    for (int i = 0; i < 3; i++) begin
      @(negedge sysClk);
      checkIdle(0, "reset");
      checkIdle(1, "reset");
    end
    validA  = 1'b0;
    validB  = 1'b0;
    sysRstN = 1'b1;
    @(negedge sysClk);
    checkIdle(0, "post-reset");
    checkIdle(1, "post-reset");

    $display("[TB] basic frame 0xA5 with parity");
    applyStimulus(0, 8'hA5, 1'b0, 1'b0);
    checkFrame(0, 1'b0, -1);
    @(negedge sysClk);
    checkIdle(0, "after A5");

    $display("[TB] no parity, two stop bits, 0x3C");
    applyStimulus(1, 8'h3C, 1'b0, 1'b0);
    checkFrame(1, 1'b0, -1);
    @(negedge sysClk);
    checkIdle(1, "after 3C");

    $display("[TB] back-to-back 0x01 then 0x80");
    applyStimulus(0, 8'h01, 1'b1, 1'b1);
    txDataA = 8'h80;
    parityA = 1'b1;
    checkFrame(0, 1'b0, -1);
    applyStimulus(0, 8'h80, 1'b1, 1'b0);
    checkFrame(0, 1'b0, -1);
    @(negedge sysClk);
    checkIdle(0, "after 80");

    $display("[TB] reset in mid-frame");
    applyStimulus(0, 8'hA5, 1'b0, 1'b0);
    checkFrame(0, 1'b0, 45);
    sysRstN = 1'b0;
    @(negedge sysClk);
    checkIdle(0, "mid-frame reset");
    sysRstN = 1'b1;
    applyStimulus(0, 8'h55, 1'b0, 1'b0);
    checkFrame(0, 1'b0, -1);
    @(negedge sysClk);
    checkIdle(0, "after 55");

    $display("[TB] input changes after accepting 0xF0");
    applyStimulus(0, 8'hF0, 1'b0, 1'b0);
    checkFrame(0, 1'b1, -1);
    validA = 1'b0;
    @(negedge sysClk);
    checkIdle(0, "after F0");
    @(negedge sysClk);
    checkIdle(0, "idle hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
